controlador_autenticacao_serial: RTL and testbench

// - Initiator/requester side of the 6-bit authentication comparator. It collects a credential

---
 rtl/controlador_autenticacao_serial.sv | 190 +++++++++++++++++++
 tb/tb_controlador_autenticacao_serial.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_autenticacao_serial.sv
// Serial credential requester for the 6-bit authentication comparator.
// Optional macro AUT_TIMEOUT_EN enables the inter-bit timeout in COLLECT.
module controlador_autenticacao_serial #(
  parameter int SETTLE_CYC  = 1,
  parameter int GRANT_CYC   = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 64,
  parameter int TIMEOUT_CYC = 255,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [1:0]    ZONE,
  input  logic          BIT_IN,
  input  logic          BIT_VALID,
  input  logic [2:0]    AUT_IN,
  output logic [5:0]    CODE,
  output logic          CODE_VALID,
  output logic          BUSY,
  output logic          GRANT,
  output logic          DENY,
  output logic          LOCKED,
  output logic [FW-1:0] FAIL_CNT
);

  localparam int M1 = (GRANT_CYC > LOCKOUT_CYC) ? GRANT_CYC : LOCKOUT_CYC;
  localparam int M2 = (M1 > SETTLE_CYC) ? M1 : SETTLE_CYC;
  localparam int M3 = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
  localparam int CW = $clog2(M3 + 1);

  localparam logic [CW-1:0] SET_END = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GRT_END = CW'(GRANT_CYC - 1);
  localparam logic [CW-1:0] LCK_END = CW'(LOCKOUT_CYC - 1);
`ifdef AUT_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_END = CW'(TIMEOUT_CYC - 1);
`endif
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SETTLE,
    S_DECIDE,
    S_GRANT,
    S_DENY,
    S_LOCKOUT
  } state_t;

  state_t        state_q;
  logic [1:0]    zone_q;
  logic [5:0]    code_q;
  logic [2:0]    bcnt_q;
  logic [CW-1:0] cnt_q;
  logic          cv_q;
  logic          grant_q;
  logic          deny_q;
  logic          locked_q;
  logic [FW-1:0] fail_q;
  logic [FW-1:0] fail_d;
  logic          hit_d;

  always_comb begin
    fail_d = fail_q;
    if (fail_q != FMAX) fail_d = fail_q + 1'b1;
  end

  // zone 3 never matches, whatever the comparator says
  always_comb begin
    hit_d = 1'b0;
    unique case (zone_q)
      2'd0: hit_d = AUT_IN[0];
      2'd1: hit_d = AUT_IN[1];
      2'd2: hit_d = AUT_IN[2];
      2'd3: hit_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      zone_q   <= 2'd0;
      code_q   <= 6'b0;
      bcnt_q   <= 3'd0;
      cnt_q    <= '0;
      cv_q     <= 1'b0;
      grant_q  <= 1'b0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            zone_q  <= ZONE;
            code_q  <= 6'b0;
            bcnt_q  <= 3'd0;
            cnt_q   <= '0;
            state_q <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (BIT_VALID) begin
            code_q <= {code_q[4:0], BIT_IN};
            cnt_q  <= '0;
            if (bcnt_q == 3'd5) begin
              cv_q    <= 1'b1;
              state_q <= S_SETTLE;
            end else begin
              bcnt_q <= bcnt_q + 3'd1;
            end
          end
`ifdef AUT_TIMEOUT_EN
          else if (cnt_q == TMO_END) begin
            cnt_q   <= '0;
            deny_q  <= 1'b1;
            state_q <= S_DENY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_SETTLE: begin
          if (cnt_q == SET_END) begin
            cnt_q   <= '0;
            state_q <= S_DECIDE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DECIDE: begin
          cnt_q <= '0;
          if (hit_d) begin
            grant_q <= 1'b1;
            fail_q  <= '0;
            state_q <= S_GRANT;
          end else begin
            deny_q  <= 1'b1;
            state_q <= S_DENY;
          end
        end
        S_GRANT: begin
          if (cnt_q == GRT_END) begin
            grant_q <= 1'b0;
            code_q  <= 6'b0;
            cv_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DENY: begin
          deny_q  <= 1'b0;
          code_q  <= 6'b0;
          cv_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
          if (zone_q != 2'd3) begin
            fail_q <= fail_d;
            if (fail_d == FMAX) begin
              locked_q <= 1'b1;
              state_q  <= S_LOCKOUT;
            end
          end
        end
        S_LOCKOUT: begin
          if (cnt_q == LCK_END) begin
            locked_q <= 1'b0;
            fail_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = cv_q;
  assign BUSY       = (state_q != S_IDLE);
  assign GRANT      = grant_q;
  assign DENY       = deny_q;
  assign LOCKED     = locked_q;
  assign FAIL_CNT   = fail_q;

endmodule

// File: tb/tb_controlador_autenticacao_serial.sv
// Bench for controlador_autenticacao_serial with a behavioural comparator.
// Define AUT_TIMEOUT_EN to also exercise the inter-bit timeout.
module tb_controlador_autenticacao_serial;

  localparam int SETTLE_CYC  = 1;
  localparam int GRANT_CYC   = 8;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 64;
  localparam int TIMEOUT_CYC = 255;

  localparam logic [5:0] K0 = 6'b110011;
  localparam logic [5:0] K1 = 6'b101101;
  localparam logic [5:0] K2 = 6'b011000;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [1:0] ZONE = 2'd0;
  logic       BIT_IN = 1'b0;
  logic       BIT_VALID = 1'b0;
  logic [2:0] AUT;
  logic [5:0] CODE;
  logic       CODE_VALID;
  logic       BUSY;
  logic       GRANT;
  logic       DENY;
  logic       LOCKED;
  logic [1:0] FAIL_CNT;

  int errors = 0;
  int checks = 0;
  int mfail = 0;

  // comparator: one stored key per zone
  assign AUT = {CODE == K2, CODE == K1, CODE == K0};

  controlador_autenticacao_serial #(
    .SETTLE_CYC (SETTLE_CYC),
    .GRANT_CYC  (GRANT_CYC),
    .MAX_FAIL   (MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ZONE      (ZONE),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .AUT_IN    (AUT),
    .CODE      (CODE),
    .CODE_VALID(CODE_VALID),
    .BUSY      (BUSY),
    .GRANT     (GRANT),
    .DENY      (DENY),
    .LOCKED    (LOCKED),
    .FAIL_CNT  (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_grant(input logic [1:0] z,
                                     input logic [5:0] c);
    case (z)
      2'd0:    return c == K0;
      2'd1:    return c == K1;
      2'd2:    return c == K2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_req(input logic [1:0] z);
    START = 1'b1;
    ZONE = z;
    BIT_VALID = 1'b1;
    BIT_IN = 1'($urandom);
    tick();
    START = 1'b0;
    BIT_VALID = 1'b0;
    ZONE = 2'($urandom_range(0, 3));
    chk("busy_after_start", 32'(BUSY), 32'd1);
  endtask

  task automatic send_bits(input logic [5:0] c, input int nbits,
                           input int maxgap);
    for (int i = 0; i < nbits; i++) begin
      int gap;
      gap = $urandom_range(0, maxgap);
      repeat (gap) begin
        START = 1'($urandom_range(0, 1));
        tick();
      end
      START = 1'b0;
      BIT_VALID = 1'b1;
      BIT_IN = c[5-i];
      tick();
      BIT_VALID = 1'b0;
    end
  endtask

  task automatic request(input logic [1:0] z, input logic [5:0] c);
    int n;
    logic g;
    start_req(z);
    send_bits(c, 6, 3);
    chk("code_after_bit6", 32'(CODE), 32'(c));
    chk("code_valid", 32'(CODE_VALID), 32'd1);
    n = 0;
    while (!(GRANT || DENY) && n < 20) begin
      tick();
      n++;
    end
    chk("decision_latency", n, SETTLE_CYC + 1);
    g = exp_grant(z, c);
    chk("grant", 32'(GRANT), 32'(g));
    chk("deny", 32'(DENY), 32'(!g));
    if (g) begin
      mfail = 0;
      n = 0;
      while (GRANT && n < 100) begin
        START = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      START = 1'b0;
      chk("grant_len", n, GRANT_CYC);
      chk("fail_after_grant", 32'(FAIL_CNT), 32'd0);
      chk("idle_after_grant", 32'(BUSY), 32'd0);
      chk("code_cleared", 32'(CODE), 32'd0);
      chk("cv_cleared", 32'(CODE_VALID), 32'd0);
    end else begin
      tick();
      chk("deny_one_cycle", 32'(DENY), 32'd0);
      if (z != 2'd3) mfail++;
      chk("fail_cnt", 32'(FAIL_CNT), mfail);
      if (mfail == MAX_FAIL) begin
        chk("locked", 32'(LOCKED), 32'd1);
        n = 0;
        while (LOCKED && n < 200) begin
          START = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        START = 1'b0;
        mfail = 0;
        chk("lock_len", n, LOCKOUT_CYC);
        chk("fail_after_lock", 32'(FAIL_CNT), 32'd0);
        chk("idle_after_lock", 32'(BUSY), 32'd0);
      end else begin
        chk("no_lock", 32'(LOCKED), 32'd0);
        chk("idle_after_deny", 32'(BUSY), 32'd0);
      end
    end
  endtask

  initial begin
    logic [5:0] rc;
    logic [1:0] rz;
    int n;

    tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_code", 32'(CODE), 32'd0);
    chk("rst_outs", 32'({CODE_VALID, GRANT, DENY, LOCKED}), 32'd0);
    chk("rst_fail", 32'(FAIL_CNT), 32'd0);
    RST_N = 1'b1;
    tick();
    chk("post_rst_busy", 32'(BUSY), 32'd0);

    request(2'd2, K2);
    request(2'd0, K2);
    request(2'd0, K2);
    request(2'd0, K2);
    request(2'd3, K1);
    request(2'd3, K2);
    request(2'd1, K0);

    // abort mid-collect
    start_req(2'd1);
    send_bits(K1, 3, 2);
    RST_N = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_code", 32'(CODE), 32'd0);
    chk("abort_fail", 32'(FAIL_CNT), 32'd0);
    mfail = 0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      BIT_VALID = 1'($urandom_range(0, 1));
      BIT_IN = 1'($urandom);
      tick();
    end
    BIT_VALID = 1'b0;
    chk("quiet_busy", 32'(BUSY), 32'd0);
    chk("quiet_code", 32'(CODE), 32'd0);
    chk("quiet_outs", 32'({CODE_VALID, GRANT, DENY, LOCKED}), 32'd0);

`ifdef AUT_TIMEOUT_EN
    start_req(2'd1);
    send_bits(K1, 2, 0);
    n = 0;
    while (!DENY && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT_CYC);
    tick();
    mfail++;
    chk("timeout_fail", 32'(FAIL_CNT), mfail);
    chk("timeout_idle", 32'(BUSY), 32'd0);
`endif

    for (int t = 0; t < 24; t++) begin
      rz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rc = K0;
        1:       rc = K1;
        2:       rc = K2;
        default: rc = 6'($urandom);
      endcase
      request(rz, rc);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
